// File: rtl/tap_delay_sequencer.sv
// Sample-history delay line: stores each accepted sample in a circular buffer and
// replays the newest TAPS samples (x[n] .. x[n-TAPS+1]) as a valid/ready tap stream.
module tap_delay_sequencer #(
  parameter int TAPS = 16,
  parameter int AW   = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [15:0]   in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [15:0]   tap_data,
  output logic [AW-1:0] tap_idx,
  output logic          tap_valid,
  input  logic          tap_ready,
  output logic          tap_last,
  input  logic          flush,
  output logic          busy
);

  localparam int DEPTH = 2 ** AW;
  localparam logic [AW-1:0] LAST_K  = AW'(TAPS - 1);
  localparam logic [AW-1:0] CLR_END = '1;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    SCAN  = 2'd2
  } state_t;

  state_t        state_q;
  logic [15:0]   tap_data_q;
  logic [AW-1:0] tap_idx_q;
  logic          tap_valid_q;
  logic          tap_last_q;
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] clr_cnt_q;
  logic          flush_pend_q;

  logic [15:0]   mem [DEPTH];

  logic          accept;
  logic          tap_hs;
  logic [AW-1:0] k_nxt;
  logic [AW-1:0] rd_addr;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [15:0]   mem_wdata;

  assign in_ready  = (state_q == IDLE) & ~flush_pend_q & ~flush;
  assign busy      = (state_q != IDLE);
  assign tap_data  = tap_data_q;
  assign tap_idx   = tap_idx_q;
  assign tap_valid = tap_valid_q;
  assign tap_last  = tap_last_q;

  // tap_idx_q doubles as the scan position k.
  assign accept  = in_valid & in_ready;
  assign tap_hs  = tap_valid_q & tap_ready;
  assign k_nxt   = tap_idx_q + 1'b1;
  assign rd_addr = wr_ptr_q - k_nxt;

  assign mem_we    = (state_q == CLEAR) | accept;
  assign mem_waddr = (state_q == CLEAR) ? clr_cnt_q : wr_ptr_q;
  assign mem_wdata = (state_q == CLEAR) ? 16'd0 : in_data;

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= CLEAR;
      tap_data_q   <= '0;
      tap_idx_q    <= '0;
      tap_valid_q  <= 1'b0;
      tap_last_q   <= 1'b0;
      wr_ptr_q     <= '0;
      clr_cnt_q    <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      case (state_q)
        CLEAR: begin
          clr_cnt_q   <= clr_cnt_q + 1'b1;
          tap_valid_q <= 1'b0;
          if (clr_cnt_q == CLR_END) begin
            wr_ptr_q     <= '0;
            flush_pend_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        IDLE: begin
          if (flush) begin
            clr_cnt_q <= '0;
            state_q   <= CLEAR;
          end else if (accept) begin
            // Newest tap comes straight from the input; the write lands this edge.
            tap_data_q  <= in_data;
            tap_idx_q   <= '0;
            tap_valid_q <= 1'b1;
            tap_last_q  <= (LAST_K == '0);
            state_q     <= SCAN;
          end
        end
        SCAN: begin
          if (flush) flush_pend_q <= 1'b1;
          if (tap_hs) begin
            if (tap_idx_q != LAST_K) begin
              tap_idx_q  <= k_nxt;
              tap_data_q <= mem[rd_addr];
              tap_last_q <= (k_nxt == LAST_K);
            end else begin
              tap_valid_q <= 1'b0;
              tap_last_q  <= 1'b0;
              wr_ptr_q    <= wr_ptr_q + 1'b1;
              if (flush_pend_q | flush) begin
                clr_cnt_q <= '0;
                state_q   <= CLEAR;
              end else begin
                state_q <= IDLE;
              end
            end
          end
        end
        default: state_q <= CLEAR;
      endcase
    end
  end

endmodule
